energy_counter_mc: RTL and testbench

ENERGY_COUNTER_MC -- requirements
Module: energy_counter_mc

---
 rtl/energy_counter_mc.sv | 173 +++++++++++++++++
 tb/tb_energy_counter_mc.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/energy_counter_mc.sv
// Multi-channel edge-energy event counter with one-entry pending slots per channel
// and round-robin publication of closed events into a single output register.
module energy_counter_mc #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned CNT_WIDTH    = 12,
  parameter int unsigned HISTORY_BITS = 16
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               enable,
  input  logic [CHANNELS-1:0]                                signal_rising,
  input  logic [CHANNELS-1:0]                                signal_falling,
  output logic [CHANNELS-1:0]                                active,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_channel,
  output logic [CNT_WIDTH-1:0]                               out_energy,
  output logic                                               out_saturated,
  output logic [15:0]                                        drop_count
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned Q_W  = $clog2(HISTORY_BITS);
  localparam logic [CNT_WIDTH:0] CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};
  localparam logic [Q_W-1:0]     Q_LAST  = Q_W'(HISTORY_BITS - 1);

  typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} ch_state_t;

  logic [CHANNELS-1:0]  pend_valid;
  logic [CHANNELS-1:0]  pend_sat;
  logic [CHANNELS-1:0]  drop_v;
  logic [CNT_WIDTH-1:0] pend_energy [CHANNELS];
  logic                 can_load;
  logic                 grant_any;
  logic [CH_W-1:0]      grant_idx;
  logic [CH_W-1:0]      rr_start;
  logic [16:0]          drop_sum;

  assign can_load = ~out_valid | out_ready;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    ch_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic                 sat_q, sat_d;
    logic [Q_W-1:0]       quiet_q, quiet_d;
    logic                 hit, close, granted, at_max;
    logic [CNT_WIDTH:0]   sum;
    logic                 slot_v_q, slot_s_q;
    logic [CNT_WIDTH-1:0] slot_e_q;

    assign hit     = signal_rising[g] | signal_falling[g];
    // An idle channel sums from zero so a new event never inherits an old total
    assign sum     = ((state_q == OPEN) ? {1'b0, acc_q} : '0)
                   + (CNT_WIDTH+1)'(signal_rising[g]) + (CNT_WIDTH+1)'(signal_falling[g]);
    assign at_max  = (sum >= CNT_MAX);
    assign granted = grant_any && (grant_idx == CH_W'(g));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        acc_q   <= '0;
        sat_q   <= 1'b0;
        quiet_q <= '0;
      end else begin
        state_q <= state_d;
        acc_q   <= acc_d;
        sat_q   <= sat_d;
        quiet_q <= quiet_d;
      end
    end

    always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      sat_d   = sat_q;
      quiet_d = quiet_q;
      close   = 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && hit) begin
            state_d = OPEN;
            acc_d   = at_max ? CNT_MAX[CNT_WIDTH-1:0] : sum[CNT_WIDTH-1:0];
            sat_d   = at_max;
            quiet_d = '0;
          end
        end
        OPEN: begin
          acc_d = at_max ? CNT_MAX[CNT_WIDTH-1:0] : sum[CNT_WIDTH-1:0];
          sat_d = sat_q | at_max;
          if (hit) begin
            quiet_d = '0;
          end else if (quiet_q == Q_LAST) begin
            state_d = IDLE;
            close   = 1'b1;
          end else begin
            quiet_d = quiet_q + Q_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A slot being granted this cycle can accept the closing result directly
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_v_q <= 1'b0;
        slot_e_q <= '0;
        slot_s_q <= 1'b0;
      end else if (close && (!slot_v_q || granted)) begin
        slot_v_q <= 1'b1;
        slot_e_q <= acc_q;
        slot_s_q <= sat_q;
      end else if (granted) begin
        slot_v_q <= 1'b0;
      end
    end

    assign pend_valid[g]  = slot_v_q;
    assign pend_sat[g]    = slot_s_q;
    assign pend_energy[g] = slot_e_q;
    assign drop_v[g]      = close & slot_v_q & ~granted;
    assign active[g]      = (state_q == OPEN);
  end

  // Round-robin: lowest full slot at or above rr_start wins, else lowest below it
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (can_load) begin
      for (int c = CHANNELS - 1; c >= 0; c--) begin
        if (pend_valid[c] && (c < int'(rr_start))) begin
          grant_any = 1'b1;
          grant_idx = CH_W'(c);
        end
      end
      for (int c = CHANNELS - 1; c >= 0; c--) begin
        if (pend_valid[c] && (c >= int'(rr_start))) begin
          grant_any = 1'b1;
          grant_idx = CH_W'(c);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_channel   <= '0;
      out_energy    <= '0;
      out_saturated <= 1'b0;
      rr_start      <= '0;
    end else if (can_load) begin
      out_valid <= grant_any;
      if (grant_any) begin
        out_channel   <= grant_idx;
        out_energy    <= pend_energy[grant_idx];
        out_saturated <= pend_sat[grant_idx];
        rr_start      <= (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int c = 0; c < CHANNELS; c++) begin
      drop_sum = drop_sum + 17'(drop_v[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_count <= '0;
    else        drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
endmodule

// File: tb/tb_energy_counter_mc.sv
// Bench for energy_counter_mc: directed vector table, multi-cycle corner sequences
// and randomized traffic compared every cycle against an event-level reference model.
module tb_energy_counter_mc;
  localparam int CH   = 4;
  localparam int W    = 12;
  localparam int H    = 16;
  localparam int WS   = 4;
  localparam int MAXV = (1 << W) - 1;

  logic          clk, rst_n, enable, out_ready;
  logic [CH-1:0] rising, falling;
  logic [CH-1:0] active, s_active;
  logic          out_valid, s_out_valid, out_saturated, s_out_saturated;
  logic [1:0]    out_channel, s_out_channel;
  logic [W-1:0]  out_energy;
  logic [WS-1:0] s_out_energy;
  logic [15:0]   drop_count, s_drop_count;

  energy_counter_mc #(.CHANNELS(CH), .CNT_WIDTH(W), .HISTORY_BITS(H)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .signal_rising(rising), .signal_falling(falling), .active(active),
    .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
    .out_energy(out_energy), .out_saturated(out_saturated), .drop_count(drop_count));

  energy_counter_mc #(.CHANNELS(CH), .CNT_WIDTH(WS), .HISTORY_BITS(H)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .signal_rising(rising), .signal_falling(falling), .active(s_active),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_channel(s_out_channel),
    .out_energy(s_out_energy), .out_saturated(s_out_saturated), .drop_count(s_drop_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Event-level reference: raw unsaturated energy, time of last edge, slot contents
  int  cyc = 0;
  bit  m_open [CH];
  int  m_raw  [CH];
  int  m_last [CH];
  bit  m_pv   [CH];
  int  m_pe   [CH];
  bit  m_ps   [CH];
  int  m_next, m_och, m_oe, m_drops;
  bit  m_ov, m_os;
  bit  model_on = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int g, c, inc;
    bit can, e;
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        m_open[i] = 0; m_raw[i] = 0; m_last[i] = 0; m_pv[i] = 0; m_pe[i] = 0; m_ps[i] = 0;
      end
      m_next = 0; m_ov = 0; m_och = 0; m_oe = 0; m_os = 0; m_drops = 0;
    end else begin
      cyc++;
      can = !m_ov || out_ready;
      g = -1;
      if (can) begin
        for (int k = 0; k < CH; k++) begin
          c = (m_next + k) % CH;
          if (g < 0 && m_pv[c]) g = c;
        end
        m_ov = (g >= 0);
      end
      if (g >= 0) begin
        m_och = g; m_oe = m_pe[g]; m_os = m_ps[g]; m_pv[g] = 0; m_next = (g + 1) % CH;
      end
      for (int i = 0; i < CH; i++) begin
        e   = rising[i] | falling[i];
        inc = int'(rising[i]) + int'(falling[i]);
        if (!m_open[i]) begin
          if (enable && e) begin
            m_open[i] = 1; m_raw[i] = inc; m_last[i] = cyc;
          end
        end else begin
          m_raw[i] = (m_raw[i] + inc > (1 << 20)) ? (1 << 20) : m_raw[i] + inc;
          if (e) m_last[i] = cyc;
          else if (cyc - m_last[i] == H) begin
            m_open[i] = 0;
            if (!m_pv[i]) begin
              m_pv[i] = 1;
              m_pe[i] = (m_raw[i] > MAXV) ? MAXV : m_raw[i];
              m_ps[i] = (m_raw[i] >= MAXV);
            end else if (m_drops < 65535) begin
              m_drops++;
            end
          end
        end
      end
    end
  end

  function automatic logic [CH-1:0] m_active();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = m_open[i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && model_on) begin
      chk("model_active", 64'(active), 64'(m_active()));
      chk("model_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        chk("model_channel", 64'(out_channel), 64'(m_och));
        chk("model_energy", 64'(out_energy), 64'(m_oe));
        chk("model_saturated", 64'(out_saturated), 64'(m_os));
      end
      chk("model_drops", 64'(drop_count), 64'(m_drops));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    tick();
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int ch; bit r; bit f; int len1; int gap; int len2;
    int e; bit s; int e4; bit s4;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int last, nres;
    out_ready = 1'b1; enable = 1'b1; last = 0; nres = 0;
    for (int i = 0; i < v.len1 + v.gap + v.len2; i++) begin
      tick();
      rising = '0; falling = '0;
      if (i < v.len1 || i >= v.len1 + v.gap) begin
        rising[v.ch] = v.r; falling[v.ch] = v.f; last = cyc + 1;
      end
    end
    for (int i = 0; i < 60; i++) begin
      tick();
      rising = '0; falling = '0;
      if (out_valid) begin
        nres++;
        if (nres == 1) begin
          chk($sformatf("vec%0d_channel", idx), 64'(out_channel), 64'(v.ch));
          chk($sformatf("vec%0d_energy", idx), 64'(out_energy), 64'(v.e));
          chk($sformatf("vec%0d_saturated", idx), 64'(out_saturated), 64'(v.s));
          chk($sformatf("vec%0d_latency", idx), 64'(cyc + 1 - last), 64'(H + 2));
          chk($sformatf("vec%0d_small_valid", idx), 64'(s_out_valid), 64'(1));
          chk($sformatf("vec%0d_small_channel", idx), 64'(s_out_channel), 64'(v.ch));
          chk($sformatf("vec%0d_small_energy", idx), 64'(s_out_energy), 64'(v.e4));
          chk($sformatf("vec%0d_small_saturated", idx), 64'(s_out_saturated), 64'(v.s4));
        end
      end
    end
    chk($sformatf("vec%0d_result_count", idx), 64'(nres), 64'(1));
  endtask

  int q_ch[$];
  int q_cy[$];

  task automatic burst_order(input logic [CH-1:0] mask, input int exp[4], input int n,
                             input string name);
    tick();
    rising = mask; falling = '0; out_ready = 1'b1; enable = 1'b1;
    q_ch.delete(); q_cy.delete();
    for (int i = 0; i < 24; i++) begin
      tick();
      rising = '0;
      if (out_valid) begin
        q_ch.push_back(int'(out_channel));
        q_cy.push_back(cyc);
      end
    end
    chk({name, "_count"}, 64'(q_ch.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < q_ch.size()) chk($sformatf("%s_order%0d", name, i), 64'(q_ch[i]), 64'(exp[i]));
      if (i > 0 && i < q_ch.size())
        chk($sformatf("%s_gap%0d", name, i), 64'(q_cy[i] - q_cy[i-1]), 64'(1));
    end
  endtask

  bit held;
  task automatic ch3_event_hold(input int k);
    for (int i = 0; i < k + 18; i++) begin
      tick();
      rising = '0;
      if (i < k) rising[3] = 1'b1;
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_channel", 64'(out_channel), 64'(3));
        chk("hold_energy", 64'(out_energy), 64'(1));
        chk("hold_saturated", 64'(out_saturated), 64'(0));
      end else if (out_valid) begin
        held = 1'b1;
      end
    end
  endtask

  vec_t vecs[6];
  int   dens[CH];
  int   ready_p, cnt;

  initial begin
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0; rising = '0; falling = '0;
    repeat (2) tick();
    chk("reset_active", 64'(active), 64'(0));
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_channel", 64'(out_channel), 64'(0));
    chk("reset_energy", 64'(out_energy), 64'(0));
    chk("reset_saturated", 64'(out_saturated), 64'(0));
    chk("reset_drops", 64'(drop_count), 64'(0));
    chk("reset_small_active", 64'(s_active), 64'(0));
    chk("reset_small_drops", 64'(s_drop_count), 64'(0));
    rst_n = 1'b1;
    model_on = 1'b1;

    vecs[0] = '{0, 1'b1, 1'b0, 10, 0,  0, 10, 1'b0, 10, 1'b0};
    vecs[1] = '{1, 1'b1, 1'b1, 3,  15, 1, 8,  1'b0, 8,  1'b0};
    vecs[2] = '{2, 1'b1, 1'b1, 10, 0,  0, 20, 1'b0, 15, 1'b1};
    vecs[3] = '{3, 1'b0, 1'b1, 6,  0,  0, 6,  1'b0, 6,  1'b0};
    vecs[4] = '{1, 1'b1, 1'b1, 8,  0,  0, 16, 1'b0, 15, 1'b1};
    vecs[5] = '{0, 1'b1, 1'b1, 2,  10, 3, 10, 1'b0, 10, 1'b0};
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    reset_dut();
    burst_order(4'b1111, '{0, 1, 2, 3}, 4, "rr_first");
    burst_order(4'b1111, '{0, 1, 2, 3}, 4, "rr_repeat");
    burst_order(4'b0100, '{2, 0, 0, 0}, 1, "rr_single");
    burst_order(4'b1111, '{3, 0, 1, 2}, 4, "rr_rotated");

    reset_dut();
    out_ready = 1'b0; enable = 1'b1; held = 1'b0;
    ch3_event_hold(1);
    ch3_event_hold(2);
    ch3_event_hold(3);
    chk("drop_count_one", 64'(drop_count), 64'(1));
    chk("drop_held_energy", 64'(out_energy), 64'(1));
    out_ready = 1'b1;
    tick();
    chk("drop_second_valid", 64'(out_valid), 64'(1));
    chk("drop_second_energy", 64'(out_energy), 64'(2));
    tick();
    chk("drop_third_absent", 64'(out_valid), 64'(0));

    out_ready = 1'b0;
    tick(); rising[1] = 1'b1;
    tick(); rising = '0;
    repeat (3) tick();
    rising[0] = 1'b1;
    tick(); rising = '0;
    repeat (20) tick();
    rising[0] = 1'b1;
    tick(); rising = '0;
    tick();
    chk("prereset_valid", 64'(out_valid), 64'(1));
    chk("prereset_ch0_open", 64'(active[0]), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_active", 64'(active), 64'(0));
    chk("midreset_valid", 64'(out_valid), 64'(0));
    chk("midreset_channel", 64'(out_channel), 64'(0));
    chk("midreset_energy", 64'(out_energy), 64'(0));
    chk("midreset_saturated", 64'(out_saturated), 64'(0));
    chk("midreset_drops", 64'(drop_count), 64'(0));
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("postreset_no_result", 64'(cnt), 64'(0));
    rising[0] = 1'b1;
    tick(); enable = 1'b0;
    tick(); rising = '0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid && cnt == 0) begin
        cnt = 1;
        chk("fresh_channel", 64'(out_channel), 64'(0));
        chk("fresh_energy", 64'(out_energy), 64'(2));
      end
    end
    chk("fresh_seen", 64'(cnt), 64'(1));
    enable = 1'b1;

    ready_p = 100;
    for (int i = 0; i < CH; i++) dens[i] = 0;
    for (int t = 0; t < 3000; t++) begin
      tick();
      if (t % 50 == 0) begin
        for (int i = 0; i < CH; i++) begin
          case ($urandom_range(0, 2))
            0:       dens[i] = 0;
            1:       dens[i] = 3;
            default: dens[i] = 30;
          endcase
        end
      end
      if (t % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       ready_p = 10;
          1:       ready_p = 60;
          default: ready_p = 100;
        endcase
      end
      for (int i = 0; i < CH; i++) begin
        rising[i]  = ($urandom_range(0, 99) < dens[i]);
        falling[i] = ($urandom_range(0, 99) < dens[i]);
      end
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 99) < ready_p);
    end
    rising = '0; falling = '0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
